// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one combinational-read memory port between instruction fetch
// and load/store. Every output is driven straight from a flop, so reset clears them at once.
module mem_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int SEL_WIDTH   = 4,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_valid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  d_req,
  input  logic [SEL_WIDTH-1:0]  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_valid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  mem_en,
  output logic [SEL_WIDTH-1:0]  mem_write_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;
  typedef enum logic {PRIO_DATA = 1'b0, PRIO_INST = 1'b1} prio_t;

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

  state_t                state_q, state_d;
  prio_t                 prio_q, prio_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  owner_q, owner_d;  // 1 = load/store port owns the access
  logic                  mem_en_q, mem_en_d;
  logic [SEL_WIDTH-1:0]  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  if_valid_q, if_valid_d;
  logic                  d_valid_q, d_valid_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
  logic                  busy_q, busy_d;
  logic                  grant_d_s;

  // State register and all output flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      prio_q      <= PRIO_DATA;
      cnt_q       <= 4'd0;
      owner_q     <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_valid_q  <= if_valid_d;
      d_valid_q   <= d_valid_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state, arbitration and capture logic
  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_valid_d  = 1'b0;
    d_valid_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    busy_d      = busy_q;
    grant_d_s   = d_req && (!if_req || (prio_q == PRIO_DATA));
    case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          // The latched request doubles as the memory port drive for the whole access
          state_d     = ACCESS;
          owner_d     = grant_d_s;
          prio_d      = grant_d_s ? PRIO_INST : PRIO_DATA;
          cnt_d       = 4'd0;
          mem_en_d    = 1'b1;
          mem_addr_d  = grant_d_s ? d_addr : if_addr;
          mem_we_d    = grant_d_s ? d_we : '0;
          mem_wdata_d = grant_d_s ? d_wdata : '0;
          busy_d      = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (cnt_q == WAIT_LAST) begin
          state_d     = RESP;
          mem_en_d    = 1'b0;
          mem_we_d    = '0;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
          if (owner_q) begin
            d_valid_d = 1'b1;
            d_rdata_d = (mem_we_q != '0) ? '0 : mem_read_data;
          end else begin
            if_valid_d = 1'b1;
            if_rdata_d = mem_read_data;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d  = IDLE;
        mem_en_d = 1'b0;
        mem_we_d = '0;
        busy_d   = 1'b0;
      end
    endcase
  end

  assign if_valid       = if_valid_q;
  assign if_rdata       = if_rdata_q;
  assign d_valid        = d_valid_q;
  assign d_rdata        = d_rdata_q;
  assign mem_en         = mem_en_q;
  assign mem_write_en   = mem_we_q;
  assign mem_addr       = mem_addr_q;
  assign mem_write_data = mem_wdata_q;
  assign busy           = busy_q;

endmodule
